slave_mem_responder: RTL

SLAVE_MEM_RESPONDER -- requirements
Module: slave_mem_responder

---
 rtl/slave_mem_responder_pkg.sv | 22 ++
 rtl/slave_mem_responder_sync_fifo.sv | 59 +++++
 rtl/slave_mem_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/slave_mem_responder_pkg.sv
// Shared types for the slave memory responder: FSM states and the buffered request record.
package slave_mem_responder_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic                  cmd;
    logic [ADDR_MAX_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/slave_mem_responder_sync_fifo.sv
// Synchronous FIFO with occupancy counter; push is refused when full, pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never visible once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/slave_mem_responder.sv
// Crossbar slave: buffers read/write requests and serves them in order from a word memory.
module slave_mem_responder
  import slave_mem_responder_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              resp,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  req_t              cur_q, cur_d, push_data_s, head_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_q, rd_d, rdata_q, rdata_d;
  logic              ack_q, ack_d, resp_q, resp_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              fifo_full_s, fifo_empty_s, pop_s, mem_we_s;
  logic [IDX_W-1:0]  idx_s;
  logic              unused_addr_s;

  assign push_data_s   = '{cmd: cmd, addr: ADDR_MAX_W'(addr), wdata: wdata};
  assign idx_s         = cur_q.addr[IDX_W-1:0];
  assign unused_addr_s = ^cur_q.addr;

  sync_fifo #(
    .WIDTH(REQ_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (req && !fifo_full_s),
    .pop  (pop_s),
    .wdata(push_data_s),
    .rdata(head_s),
    .full (fifo_full_s),
    .empty(fifo_empty_s)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    resp_d     = 1'b0;
    pop_s      = 1'b0;
    mem_we_s   = 1'b0;
    ack_d      = req && !fifo_full_s;
    drop_cnt_d = (req && fifo_full_s && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          cur_d   = head_s;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cur_q.cmd) begin
          mem_we_s = 1'b1;
          state_d  = IDLE;
        end else begin
          rd_d  = mem_q[idx_s];
          cnt_d = CNT_W'(LATENCY - 1);
          // With a single cycle of latency the response is launched straight from EXEC.
          if (LATENCY == 1) begin
            state_d = RESP;
            resp_d  = 1'b1;
            rdata_d = mem_q[idx_s];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          resp_d  = 1'b1;
          rdata_d = rd_q;
        end else begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
      resp_q     <= 1'b0;
      ack_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      ack_q      <= ack_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Memory keeps its contents across reset; only the in-flight write is suppressed.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[idx_s] <= cur_q.wdata;
    end
  end

  assign ack      = ack_q;
  assign resp     = resp_q;
  assign rdata    = rdata_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != IDLE) || !fifo_empty_s;

endmodule
